// File: rtl/bclk_frame_gen_if.sv
// rtl/bclk_frame_gen_if.sv - format write port and clock/status outputs of bclk_frame_gen
interface bclk_frame_gen_if;
    logic       run;
    logic [7:0] data;
    logic       data_en;
    logic       bclk;
    logic       lrck;
    logic       bclk_fall;
    logic       frame_start;
    logic       cfg_pending;
    logic       cfg_err;
    logic       mute;
    logic [7:0] cur_cfg;

    modport master (
        output run, data, data_en,
        input  bclk, lrck, bclk_fall, frame_start, cfg_pending, cfg_err, mute, cur_cfg
    );

    modport slave (
        input  run, data, data_en,
        output bclk, lrck, bclk_fall, frame_start, cfg_pending, cfg_err, mute, cur_cfg
    );
endinterface

// File: rtl/bclk_frame_gen.sv
// rtl/bclk_frame_gen.sv - counter-based BCLK/LRCK frame generator from MCLK; `DSD_EN adds DSD formats
module bclk_frame_gen #(
    parameter int MCLK_RATIO  = 512,
    parameter int MUTE_FRAMES = 4,
    parameter int CNT_W       = 9
) (
    input  logic            clk_in,
    input  logic            rst,
    bclk_frame_gen_if.slave io
);
    localparam int MC_W = (MUTE_FRAMES > 1) ? $clog2(MUTE_FRAMES) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    typedef struct packed {
        logic [7:0]       code;
        logic             dsd;
        logic [CNT_W-1:0] half;
        logic [CNT_W-1:0] lr_m1;
        logic [CNT_W-1:0] bits_m1;
    } fmt_t;

    // Zero means "not representable": non-integer ratio, below one cycle, or counter overflow.
    function automatic logic [CNT_W-1:0] div_exact(input int num, input int den);
        if (den <= 0 || (num % den) != 0 || (num / den) < 1 || (num / den) >= (1 << CNT_W))
            return '0;
        return CNT_W'(num / den);
    endfunction

    function automatic logic [CNT_W-1:0] pcm_half(input int wc, input int rc);
        int w4;
        if (wc == 3)
            return '0;
        w4 = (wc == 0) ? 64 : (wc == 1) ? 96 : 128;
        case (rc)
            0:       return div_exact(MCLK_RATIO, w4);
            1:       return div_exact(MCLK_RATIO, 2 * w4);
            2:       return div_exact(MCLK_RATIO, 4 * w4);
            default: return div_exact(3 * MCLK_RATIO, 8 * w4);
        endcase
    endfunction

    localparam fmt_t RST_FMT = '{code: 8'h00, dsd: 1'b0, half: div_exact(MCLK_RATIO, 64),
                                 lr_m1: CNT_W'(15), bits_m1: CNT_W'(31)};

`ifdef DSD_EN
    localparam logic [CNT_W-1:0] DSD_HALF0 = div_exact(MCLK_RATIO, 128);
    localparam logic [CNT_W-1:0] DSD_HALF1 = div_exact(MCLK_RATIO, 256);
    localparam logic [CNT_W-1:0] DSD_HALF2 = div_exact(MCLK_RATIO, 512);
`endif

    logic [CNT_W-1:0] half_tab [16];
    for (genvar g = 0; g < 16; g++) begin : g_half
        assign half_tab[g] = pcm_half(g / 4, g % 4);
    end

    state_t           state, nxt_state;
    fmt_t             cur, nxt_cur, sh, nxt_sh, wr_fmt;
    logic             wr_ok, wr_accept, div_tc;
    logic [CNT_W-1:0] div_cnt, nxt_div, bit_cnt, nxt_bit;
    logic             bclk, nxt_bclk, lrck, nxt_lrck;
    logic             bclk_fall, nxt_bclk_fall, frame_start, nxt_frame_start;
    logic             pending, nxt_pending, err, nxt_err, mute, nxt_mute;
    logic [MC_W-1:0]  mute_cnt, nxt_mute_cnt;

    always_comb begin
        wr_fmt      = '0;
        wr_fmt.code = io.data;
        wr_ok       = 1'b0;
        if (io.data[7]) begin
`ifdef DSD_EN
            wr_fmt.dsd     = 1'b1;
            wr_fmt.lr_m1   = '1;
            wr_fmt.bits_m1 = CNT_W'(31);
            case (io.data[2:0])
                3'b000:  wr_fmt.half = DSD_HALF0;
                3'b001:  wr_fmt.half = DSD_HALF1;
                3'b010:  wr_fmt.half = DSD_HALF2;
                default: wr_fmt.half = '0;
            endcase
            wr_ok = (io.data[6:3] == 4'b0000) && (wr_fmt.half != '0);
`endif
        end else begin
            wr_fmt.half = io.data[2] ? '0 : half_tab[{io.data[6:5], io.data[1:0]}];
            case (io.data[6:5])
                2'b00: begin
                    wr_fmt.lr_m1   = CNT_W'(15);
                    wr_fmt.bits_m1 = CNT_W'(31);
                end
                2'b01: begin
                    wr_fmt.lr_m1   = CNT_W'(23);
                    wr_fmt.bits_m1 = CNT_W'(47);
                end
                default: begin
                    wr_fmt.lr_m1   = CNT_W'(31);
                    wr_fmt.bits_m1 = CNT_W'(63);
                end
            endcase
            wr_ok = (io.data[4:3] == 2'b00) && (wr_fmt.half != '0);
        end
    end

    always_comb begin
        nxt_state       = state;
        nxt_cur         = cur;
        nxt_sh          = sh;
        nxt_div         = div_cnt;
        nxt_bit         = bit_cnt;
        nxt_bclk        = bclk;
        nxt_lrck        = lrck;
        nxt_bclk_fall   = 1'b0;
        nxt_frame_start = 1'b0;
        nxt_pending     = pending;
        nxt_err         = err;
        nxt_mute        = mute;
        nxt_mute_cnt    = mute_cnt;
        wr_accept       = io.data_en && wr_ok;
        div_tc          = (div_cnt == cur.half - 1'b1);
        if (io.data_en)
            nxt_err = !wr_ok;

        case (state)
            ST_IDLE: begin
                nxt_mute     = 1'b1;
                nxt_mute_cnt = '0;
                if (wr_accept) begin
                    nxt_cur     = wr_fmt;
                    nxt_pending = 1'b0;
                end else if (pending) begin
                    nxt_cur     = sh;
                    nxt_pending = 1'b0;
                end
                if (io.run) begin
                    nxt_state       = ST_RUN;
                    nxt_frame_start = 1'b1;
                    nxt_div         = '0;
                    nxt_bit         = '0;
                    nxt_bclk        = 1'b0;
                    nxt_lrck        = 1'b0;
                end
            end
            default: begin
                if (wr_accept) begin
                    nxt_sh      = wr_fmt;
                    nxt_pending = 1'b1;
                end
                if (div_tc) begin
                    nxt_div  = '0;
                    nxt_bclk = !bclk;
                    if (bclk) begin
                        nxt_bclk_fall = 1'b1;
                        if (bit_cnt == cur.bits_m1) begin
                            // Frame boundary: stop wins over apply; a coincident write stays pending.
                            nxt_bit  = '0;
                            nxt_lrck = 1'b0;
                            if (!io.run) begin
                                nxt_state    = ST_IDLE;
                                nxt_mute     = 1'b1;
                                nxt_mute_cnt = '0;
                            end else begin
                                nxt_frame_start = 1'b1;
                                if (pending) begin
                                    nxt_cur      = sh;
                                    nxt_mute     = 1'b1;
                                    nxt_mute_cnt = '0;
                                    if (!wr_accept)
                                        nxt_pending = 1'b0;
                                end else if (mute) begin
                                    if (mute_cnt == MC_W'(MUTE_FRAMES - 1))
                                        nxt_mute = 1'b0;
                                    else
                                        nxt_mute_cnt = mute_cnt + 1'b1;
                                end
                            end
                        end else begin
                            nxt_bit = bit_cnt + 1'b1;
                            if (bit_cnt == cur.lr_m1 && !cur.dsd)
                                nxt_lrck = 1'b1;
                        end
                    end
                end else begin
                    nxt_div = div_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cur         <= RST_FMT;
            sh          <= RST_FMT;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            bclk        <= 1'b0;
            lrck        <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            pending     <= 1'b0;
            err         <= 1'b0;
            mute        <= 1'b1;
            mute_cnt    <= '0;
        end else begin
            state       <= nxt_state;
            cur         <= nxt_cur;
            sh          <= nxt_sh;
            div_cnt     <= nxt_div;
            bit_cnt     <= nxt_bit;
            bclk        <= nxt_bclk;
            lrck        <= nxt_lrck;
            bclk_fall   <= nxt_bclk_fall;
            frame_start <= nxt_frame_start;
            pending     <= nxt_pending;
            err         <= nxt_err;
            mute        <= nxt_mute;
            mute_cnt    <= nxt_mute_cnt;
        end
    end

    assign io.bclk        = bclk;
    assign io.lrck        = lrck;
    assign io.bclk_fall   = bclk_fall;
    assign io.frame_start = frame_start;
    assign io.cfg_pending = pending;
    assign io.cfg_err     = err;
    assign io.mute        = mute;
    assign io.cur_cfg     = cur.code;
endmodule

// File: tb/tb_bclk_frame_gen.sv
// tb/tb_bclk_frame_gen.sv - directed self-checking bench for bclk_frame_gen
module tb_bclk_frame_gen;
    logic clk_in;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n;

    bclk_frame_gen_if io();

    bclk_frame_gen #(.MCLK_RATIO(512), .MUTE_FRAMES(4), .CNT_W(9)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .io     (io.slave)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b);
        io.data    = b;
        io.data_en = 1'b1;
        step(1);
        io.data_en = 1'b0;
    endtask

    task automatic count_to_fs(output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!io.frame_start && cyc < 2000);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_bclk"}, io.bclk, 1'b0);
        chk({tag, "_lrck"}, io.lrck, 1'b0);
        chk({tag, "_fall"}, io.bclk_fall, 1'b0);
        chk({tag, "_fs"}, io.frame_start, 1'b0);
        chk({tag, "_pend"}, io.cfg_pending, 1'b0);
        chk({tag, "_err"}, io.cfg_err, 1'b0);
        chk({tag, "_mute"}, io.mute, 1'b1);
        chk({tag, "_cfg"}, io.cur_cfg, 8'h00);
    endtask

    logic [7:0] tab_byte [6];
    logic       tab_err  [6];
    logic [7:0] tab_cfg  [6];

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst        = 1'b0;
        io.run     = 1'b0;
        io.data    = 8'h00;
        io.data_en = 1'b0;
        tab_byte = '{8'h03, 8'h43, 8'h60, 8'h23, 8'h05, 8'h08};
        tab_err  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1};
        tab_cfg  = '{8'h03, 8'h03, 8'h03, 8'h23, 8'h23, 8'h23};
        step(3);
        chk_reset_state("rst");

        // 1: 16b 1x start-up timing and mute release
        rst = 1'b1;
        step(1);
        wr(8'h00);
        chk("t1_err", io.cfg_err, 1'b0);
        io.run = 1'b1;
        step(1);
        chk("t1_fs1", io.frame_start, 1'b1);
        chk("t1_mute_start", io.mute, 1'b1);
        step(7);
        chk("t1_bclk_lo", io.bclk, 1'b0);
        step(1);
        chk("t1_bclk_rise", io.bclk, 1'b1);
        step(8);
        chk("t1_bclk_fall", io.bclk, 1'b0);
        chk("t1_fall_pulse", io.bclk_fall, 1'b1);
        count_to_fs(n);
        chk("t1_frame_rest", n, 496);
        count_to_fs(n);
        chk("t1_frame_len", n, 512);
        step(255);
        chk("t1_lrck_lo", io.lrck, 1'b0);
        step(1);
        chk("t1_lrck_hi", io.lrck, 1'b1);
        count_to_fs(n);
        chk("t1_half_frame", n, 256);
        chk("t1_mute_fs4", io.mute, 1'b1);
        count_to_fs(n);
        chk("t1_frame_fs5", n, 512);
        chk("t1_mute_fs5", io.mute, 1'b0);

        // 2: switch to 32b 4x mid-frame
        step(100);
        wr(8'h42);
        chk("t2_pend", io.cfg_pending, 1'b1);
        chk("t2_cfg_old", io.cur_cfg, 8'h00);
        count_to_fs(n);
        chk("t2_old_done", n, 411);
        chk("t2_cfg_new", io.cur_cfg, 8'h42);
        chk("t2_pend_clr", io.cfg_pending, 1'b0);
        chk("t2_mute", io.mute, 1'b1);
        chk("t2_bclk0", io.bclk, 1'b0);
        chk("t2_lrck0", io.lrck, 1'b0);
        step(1);
        chk("t2_bclk_hi", io.bclk, 1'b1);
        step(1);
        chk("t2_bclk_lo", io.bclk, 1'b0);
        chk("t2_fall", io.bclk_fall, 1'b1);
        count_to_fs(n);
        chk("t2_frame_rest", n, 126);
        count_to_fs(n);
        chk("t2_frame2", n, 128);
        count_to_fs(n);
        chk("t2_mute_fs3", io.mute, 1'b1);
        count_to_fs(n);
        chk("t2_frame4", n, 128);
        chk("t2_mute_fs4", io.mute, 1'b0);
        step(63);
        chk("t2_lrck_lo", io.lrck, 1'b0);
        step(1);
        chk("t2_lrck_hi", io.lrck, 1'b1);

        // 3: rejected write leaves everything untouched
        wr(8'h20);
        chk("t3_err", io.cfg_err, 1'b1);
        chk("t3_pend", io.cfg_pending, 1'b0);
        chk("t3_cfg", io.cur_cfg, 8'h42);
        count_to_fs(n);
        chk("t3_frame_rest", n, 63);
        count_to_fs(n);
        chk("t3_frame", n, 128);
        chk("t3_mute", io.mute, 1'b0);
        wr(8'h40);
        chk("t3_err_clr", io.cfg_err, 1'b0);
        chk("t3_pend40", io.cfg_pending, 1'b1);

        // 4: last write wins; coincident writes land one frame later
        wr(8'h00);
        wr(8'h41);
        count_to_fs(n);
        chk("t4_rest", n, 125);
        chk("t4_cfg41", io.cur_cfg, 8'h41);
        chk("t4_pend_clr", io.cfg_pending, 1'b0);
        chk("t4_mute", io.mute, 1'b1);
        count_to_fs(n);
        chk("t4_frame41", n, 256);
        step(255);
        wr(8'h42);
        chk("t4_coin_fs", io.frame_start, 1'b1);
        chk("t4_coin_cfg", io.cur_cfg, 8'h41);
        chk("t4_coin_pend", io.cfg_pending, 1'b1);
        count_to_fs(n);
        chk("t4_coin_frame", n, 256);
        chk("t4_coin_applied", io.cur_cfg, 8'h42);
        step(10);
        wr(8'h00);
        step(116);
        wr(8'h41);
        chk("t4_sh_fs", io.frame_start, 1'b1);
        chk("t4_sh_cfg", io.cur_cfg, 8'h00);
        chk("t4_sh_pend", io.cfg_pending, 1'b1);
        count_to_fs(n);
        chk("t4_sh_frame", n, 512);
        chk("t4_sh_applied", io.cur_cfg, 8'h41);

        // 5: stop mid-frame, then reset mid-frame
        step(50);
        io.run = 1'b0;
        step(1);
        step(204);
        chk("t5_last_bclk", io.bclk, 1'b1);
        chk("t5_last_lrck", io.lrck, 1'b1);
        step(1);
        chk("t5_park_bclk", io.bclk, 1'b0);
        chk("t5_park_lrck", io.lrck, 1'b0);
        chk("t5_no_fs", io.frame_start, 1'b0);
        step(20);
        chk("t5_idle_bclk", io.bclk, 1'b0);
        chk("t5_idle_mute", io.mute, 1'b1);
        wr(8'h18);
        chk("t5_err18", io.cfg_err, 1'b1);
        io.run = 1'b1;
        step(1);
        chk("t5_restart_fs", io.frame_start, 1'b1);
        step(30);
        chk("t5_pre_rst_bclk", io.bclk, 1'b1);
        rst    = 1'b0;
        io.run = 1'b0;
        step(1);
        chk_reset_state("t5_rst");
        rst = 1'b1;
        step(1);

        // 6: DSD selection
`ifdef DSD_EN
        wr(8'h80);
        chk("t6_dsd_err", io.cfg_err, 1'b0);
        chk("t6_dsd_cfg", io.cur_cfg, 8'h80);
        io.run = 1'b1;
        step(1);
        chk("t6_dsd_fs", io.frame_start, 1'b1);
        step(3);
        chk("t6_dsd_lo", io.bclk, 1'b0);
        step(1);
        chk("t6_dsd_hi", io.bclk, 1'b1);
        count_to_fs(n);
        chk("t6_dsd_frame", n, 252);
        chk("t6_dsd_lrck", io.lrck, 1'b0);
        io.run = 1'b0;
        step(300);
`else
        wr(8'h80);
        chk("t6_dsd_err", io.cfg_err, 1'b1);
        chk("t6_dsd_cfg", io.cur_cfg, 8'h00);
`endif

        // Validation table, written while stopped so accepted codes apply at once
        for (int i = 0; i < 6; i++) begin
            wr(tab_byte[i]);
            chk($sformatf("tab_err_%02h", tab_byte[i]), io.cfg_err, tab_err[i]);
            chk($sformatf("tab_cfg_%02h", tab_byte[i]), io.cur_cfg, tab_cfg[i]);
        end
        io.run = 1'b1;
        step(1);
        chk("t7_fs", io.frame_start, 1'b1);
        count_to_fs(n);
        chk("t7_frame_23", n, 192);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
